// File: rtl/crit_guarded_writer_pkg.sv
// Shared types and constants for the crit-guarded writer and its reader-side latch bank.
package crit_guarded_writer_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BLOCKED = 2'd1,
    ST_GUARD   = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/crit_guarded_writer_if.sv
// Upstream valid/ready word stream, reader crit flag and writer status outputs.
interface crit_guarded_writer_if
  import crit_guarded_writer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) ();

  logic [WIDTH-1:0]      dataIn;
  logic                  validIn;
  logic                  readyOut;
  logic                  crit;
  logic [WIDTH-1:0]      dataOut;
  logic                  updateOut;
  logic [clog2(DEPTH):0] pendingOut;
  logic                  dropOut;

  modport master (
    output dataIn, validIn, crit,
    input  readyOut, dataOut, updateOut, pendingOut, dropOut
  );

  modport slave (
    input  dataIn, validIn, crit,
    output readyOut, dataOut, updateOut, pendingOut, dropOut
  );

endinterface

// File: rtl/crit_guarded_writer_crit_fifo.sv
// Synchronous FIFO with registered full/empty/count; a word written at an edge is
// readable at the head no earlier than the following cycle (no bypass).
module crit_fifo
  import crit_guarded_writer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Storage carries no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/crit_guarded_writer.sv
// Buffers upstream words and updates dataOut only while crit_eff is low and the post-crit guard has expired.
// CRIT_GUARDED_WRITER_CRIT_SYNC_EN adds a 2-flop crit synchronizer; readyOut = !full, overflow pushes set sticky dropOut.
module crit_guarded_writer
  import crit_guarded_writer_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter int               GUARD     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                  clk,
  input logic                  rst,
  crit_guarded_writer_if.slave bus
);

  localparam int CW     = clog2(DEPTH) + 1;
  localparam int GW_RAW = clog2(GUARD + 1);
  localparam int GW     = (GW_RAW < 1) ? 1 : GW_RAW;

  logic             crit_eff;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count, count_next;
  logic [WIDTH-1:0] head;
  logic             push, pop;

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             update_q, update_d;
  logic             drop_q, drop_d;
  logic [GW-1:0]    guard_cnt_q, guard_cnt_d;
  state_e           state_q, state_d;

`ifdef CRIT_GUARDED_WRITER_CRIT_SYNC_EN
  logic [1:0] sync_q, sync_d;

  assign sync_d   = {sync_q[0], bus.crit};
  assign crit_eff = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end
`else
  assign crit_eff = bus.crit;
`endif

  assign push       = bus.validIn && !fifo_full;
  assign pop        = !crit_eff && (guard_cnt_q == '0) && !fifo_empty;
  assign count_next = fifo_count + CW'(push) - CW'(pop);

  crit_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (bus.dataIn),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    guard_cnt_d = guard_cnt_q;
    if (crit_eff)                 guard_cnt_d = GW'(GUARD);
    else if (guard_cnt_q != '0)   guard_cnt_d = guard_cnt_q - GW'(1);

    data_out_d = pop ? head : data_out_q;
    update_d   = pop;
    drop_d     = drop_q || (bus.validIn && fifo_full);

    // state_q describes the cycle after the edge, assuming crit_eff holds its level.
    state_d = state_q;
    if (count_next == '0) begin
      state_d = ST_IDLE;
    end else if (crit_eff) begin
      state_d = ST_BLOCKED;
    end else begin
      case (state_q)
        ST_DRAIN: state_d = ST_DRAIN;
        default:  state_d = (guard_cnt_d == '0) ? ST_DRAIN : ST_GUARD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q  <= RESET_VAL;
      update_q    <= 1'b0;
      drop_q      <= 1'b0;
      guard_cnt_q <= '0;
      state_q     <= ST_IDLE;
    end else begin
      data_out_q  <= data_out_d;
      update_q    <= update_d;
      drop_q      <= drop_d;
      guard_cnt_q <= guard_cnt_d;
      state_q     <= state_d;
    end
  end

  assign bus.readyOut   = !fifo_full;
  assign bus.dataOut    = data_out_q;
  assign bus.updateOut  = update_q;
  assign bus.pendingOut = fifo_count;
  assign bus.dropOut    = drop_q;

endmodule

// File: tb/tb_crit_guarded_writer.sv
// Directed scenarios plus randomized traffic against a queue-based model of the guarded writer.
module tb_crit_guarded_writer;
  import crit_guarded_writer_pkg::*;

  localparam int G  = 2;
  localparam int DP = 4;
`ifdef CRIT_GUARDED_WRITER_CRIT_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  crit_guarded_writer_if #(.WIDTH(16), .DEPTH(DP)) bus ();

  crit_guarded_writer #(
    .WIDTH     (16),
    .DEPTH     (DP),
    .GUARD     (G),
    .RESET_VAL (16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word queue plus guard countdown, advanced once per rising edge.
  logic [15:0] mq[$];
  int          m_guard;
  logic [15:0] m_data;
  bit          m_upd, m_drop, m_ok;
  state_e      m_state;
  bit          m_ce, m_full, m_pop;
  bit          ch[2];

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_guard = 0; m_data = 16'h0; m_upd = 0; m_drop = 0;
      m_state = ST_IDLE; ch[0] = 0; ch[1] = 0; m_ok = 1;
    end else if (m_ok) begin
      if (SD == 2) begin
        m_ce  = ch[1];
        ch[1] = ch[0];
        ch[0] = bus.crit;
      end else begin
        m_ce = bus.crit;
      end
      m_full = (mq.size() == DP);
      m_pop  = !m_ce && (m_guard == 0) && (mq.size() > 0);
      m_upd  = m_pop;
      if (m_pop) m_data = mq.pop_front();
      if (bus.validIn) begin
        if (m_full) m_drop = 1;
        else        mq.push_back(bus.dataIn);
      end
      m_guard = m_ce ? G : ((m_guard > 0) ? m_guard - 1 : 0);
      if (mq.size() == 0)  m_state = ST_IDLE;
      else if (m_ce)       m_state = ST_BLOCKED;
      else if (m_guard > 0) m_state = ST_GUARD;
      else                 m_state = ST_DRAIN;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("dataOut",    32'(bus.dataOut),    32'(m_data));
      chk("updateOut",  32'(bus.updateOut),  32'(m_upd));
      chk("pendingOut", 32'(bus.pendingOut), 32'(mq.size()));
      chk("readyOut",   32'(bus.readyOut),   32'(mq.size() != DP));
      chk("dropOut",    32'(bus.dropOut),    32'(m_drop));
      chk("state",      32'(dut.state_q),    32'(m_state));
    end
  end

  // One clock: drive inputs after the falling edge, return at the next falling edge.
  task automatic cyc(input logic r, input logic v, input logic [15:0] d, input logic c);
    rst         = r;
    bus.validIn = v;
    bus.dataIn  = d;
    bus.crit    = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pre_crit();
    cyc(0, 0, 16'h0, 1);
    cyc(0, 0, 16'h0, 1);
  endtask

  logic [15:0] w;
  logic        crit_r;
  logic        rdy;
  int          idx, budget;

  initial begin
    bus.validIn = 0; bus.dataIn = 0; bus.crit = 0;
    @(negedge clk);
    cyc(1, 0, 16'h0, 0);
    cyc(1, 0, 16'h0, 0);
    cyc(0, 0, 16'h0, 0);
    chk("rst_dataOut", 32'(bus.dataOut), 32'h0);
    chk("rst_pending", 32'(bus.pendingOut), 32'd0);
    chk("rst_ready",   32'(bus.readyOut), 32'd1);
    chk("rst_drop",    32'(bus.dropOut), 32'd0);

    // Basic latency: push at edge 1, dataOut changes at edge 2.
    cyc(0, 1, 16'h1234, 0);
    chk("lat_e1_pending", 32'(bus.pendingOut), 32'd1);
    chk("lat_e1_data",    32'(bus.dataOut), 32'h0);
    cyc(0, 0, 16'h0, 0);
    chk("lat_e2_data",    32'(bus.dataOut), 32'h1234);
    chk("lat_e2_upd",     32'(bus.updateOut), 32'd1);
    chk("lat_e2_pending", 32'(bus.pendingOut), 32'd0);
    cyc(0, 0, 16'h0, 0);
    chk("lat_e3_upd",     32'(bus.updateOut), 32'd0);

    // Blocking, then guard wait and back-to-back drain.
    cyc(1, 0, 16'h0, 1);
    pre_crit();
    cyc(0, 1, 16'h000A, 1);
    cyc(0, 1, 16'h000B, 1);
    cyc(0, 1, 16'h000C, 1);
    chk("blk_data",    32'(bus.dataOut), 32'h0);
    chk("blk_pending", 32'(bus.pendingOut), 32'd3);
    for (int k = 1; k <= 5 + SD; k++) begin
      cyc(0, 0, 16'h0, 0);
      if (k == 2 + SD) chk("blk_guard_hold", 32'(bus.dataOut), 32'h0);
      if (k == 3 + SD) chk("blk_pop_a", 32'({bus.updateOut, bus.dataOut}), 32'h1000A);
      if (k == 4 + SD) chk("blk_pop_b", 32'({bus.updateOut, bus.dataOut}), 32'h1000B);
      if (k == 5 + SD) chk("blk_pop_c", 32'({bus.updateOut, bus.dataOut}), 32'h1000C);
    end
    chk("blk_empty", 32'(bus.pendingOut), 32'd0);

    // crit rises mid-drain after the second pop.
    pre_crit();
    for (int k = 0; k < 4; k++) cyc(0, 1, 16'h00D0 + 16'(k), 1);
    chk("mid_full", 32'(bus.readyOut), 32'd0);
    for (int k = 1; k <= 8; k++) cyc(0, 0, 16'h0, (k >= 5));
    chk("mid_frozen",  32'(bus.dataOut), 32'h00D1);
    chk("mid_pending", 32'(bus.pendingOut), 32'd2);
    for (int k = 1; k <= 2 + SD; k++) cyc(0, 0, 16'h0, 0);
    chk("mid_guard_hold", 32'(bus.dataOut), 32'h00D1);
    cyc(0, 0, 16'h0, 0);
    chk("mid_pop_d2", 32'(bus.dataOut), 32'h00D2);
    cyc(0, 0, 16'h0, 0);
    chk("mid_pop_d3", 32'(bus.dataOut), 32'h00D3);

    // Streaming with handshake through pointer wrap.
    idx = 0; budget = 0;
    while (idx < 10 && budget < 100) begin
      rdy = bus.readyOut;
      cyc(0, 1, 16'h5000 + 16'(idx), 0);
      if (rdy) idx++;
      budget++;
    end
    if (budget >= 100) chk("stream_budget", 32'(idx), 32'd10);
    for (int k = 0; k < 4; k++) cyc(0, 0, 16'h0, 0);
    chk("stream_last", 32'(bus.dataOut), 32'h5009);
    chk("stream_drop", 32'(bus.dropOut), 32'd0);

    // Overflow: five pushes into four slots.
    pre_crit();
    for (int k = 0; k < 4; k++) cyc(0, 1, 16'h00E0 + 16'(k), 1);
    chk("ovf_ready", 32'(bus.readyOut), 32'd0);
    chk("ovf_nodrop", 32'(bus.dropOut), 32'd0);
    cyc(0, 1, 16'h00E4, 1);
    chk("ovf_drop", 32'(bus.dropOut), 32'd1);
    chk("ovf_pending", 32'(bus.pendingOut), 32'd4);
    for (int k = 0; k < 7 + SD; k++) cyc(0, 0, 16'h0, 0);
    chk("ovf_last", 32'(bus.dataOut), 32'h00E3);
    chk("ovf_sticky", 32'(bus.dropOut), 32'd1);

    // Reset with words pending.
    pre_crit();
    for (int k = 0; k < 3; k++) cyc(0, 1, 16'h00F0 + 16'(k), 1);
    chk("rmid_pending", 32'(bus.pendingOut), 32'd3);
    cyc(1, 0, 16'h0, 1);
    chk("rmid_data",    32'(bus.dataOut), 32'h0);
    chk("rmid_pending0", 32'(bus.pendingOut), 32'd0);
    chk("rmid_drop",    32'(bus.dropOut), 32'd0);
    chk("rmid_upd",     32'(bus.updateOut), 32'd0);
    cyc(0, 0, 16'h0, 0);
    chk("rmid_upd2",    32'(bus.updateOut), 32'd0);

    // Randomized traffic.
    crit_r = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) crit_r = ~crit_r;
      w = 16'($urandom);
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 6), w, crit_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
